// File: rtl/audio_sample_fifo_if.sv
// Wishbone slave bus for the audio sample FIFO: firmware-side sample writes and STATUS reads.
interface audio_sample_fifo_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_adr;
  logic [31:0] wb_mosi;
  logic [31:0] wb_miso;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_mosi,
    input  wb_miso, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_mosi,
    output wb_miso, wb_ack
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo PCM playback FIFO: Wishbone LEFT/RIGHT writes push stereo entries, a pacing
// engine pops one entry every TICKS_PER_SAMPLE clocks once START_LEVEL entries are buffered.
module audio_sample_fifo #(
  parameter int DEPTH              = 256,
  parameter int TICKS_PER_SAMPLE   = 680,
  parameter int START_LEVEL        = 40,
  parameter int NEARLY_EMPTY_LEVEL = 4
) (
  input  logic                clk,
  input  logic                reset,
  audio_sample_fifo_if.slave  wb,
  output logic                pcm_valid,
  output logic [15:0]         pcm_left,
  output logic [15:0]         pcm_right,
  output logic                playing,
  output logic                nearly_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;
  localparam logic [AW:0]   LVL_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_START  = (AW+1)'(START_LEVEL);
  localparam logic [AW:0]   LVL_NEARLY = (AW+1)'(NEARLY_EMPTY_LEVEL);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE   = TW'(1);
  localparam logic [3:0]    ADR_LEFT   = 4'd4;
  localparam logic [3:0]    ADR_RIGHT  = 4'd8;
  localparam logic [3:0]    ADR_STATUS = 4'd9;

  typedef enum logic {ST_PREFILL, ST_PLAY} state_t;

  state_t        state_q;
  logic [AW:0]   wr_q, rd_q;
  logic [TW-1:0] tick_q;
  logic [15:0]   left_q, underrun_q;
  logic [15:0]   pcm_left_q, pcm_right_q;
  logic          pcm_valid_q, playing_q, nearly_empty_q;
  logic [31:0]   mem [DEPTH];

  logic [AW:0]   level, level_d;
  logic          bus_req, wr_left, wr_right, rd_status;
  logic          full, empty, pop_due, pop, push, underrun;
  logic          unused_mosi_hi;

  assign level    = wr_q - rd_q;
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);

  // Bus requests are ignored while reset is high so a stalled write is simply dropped.
  assign bus_req   = wb.wb_cyc && wb.wb_stb && !reset;
  assign wr_left   = bus_req && wb.wb_we && (wb.wb_adr == ADR_LEFT);
  assign wr_right  = bus_req && wb.wb_we && (wb.wb_adr == ADR_RIGHT);
  assign rd_status = bus_req && !wb.wb_we && (wb.wb_adr == ADR_STATUS);

  assign pop_due  = (state_q == ST_PLAY) && (tick_q == TICK_LAST);
  assign pop      = pop_due && !empty;
  assign underrun = pop_due && empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push     = wr_right && (!full || pop);
  assign level_d  = level + (push ? LVL_ONE : '0) - (pop ? LVL_ONE : '0);

  assign wb.wb_ack  = bus_req && !(wr_right && !push);
  assign wb.wb_miso = rd_status ? {underrun_q, playing_q, nearly_empty_q, 14'(level)} : 32'd0;

  assign unused_mosi_hi = ^wb.wb_mosi[31:16];

  assign pcm_valid    = pcm_valid_q;
  assign pcm_left     = pcm_left_q;
  assign pcm_right    = pcm_right_q;
  assign playing      = playing_q;
  assign nearly_empty = nearly_empty_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q[AW-1:0]] <= {left_q, wb.wb_mosi[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_PREFILL;
      wr_q           <= '0;
      rd_q           <= '0;
      tick_q         <= '0;
      left_q         <= '0;
      underrun_q     <= '0;
      pcm_left_q     <= '0;
      pcm_right_q    <= '0;
      pcm_valid_q    <= 1'b0;
      playing_q      <= 1'b0;
      nearly_empty_q <= 1'b1;
    end else begin
      if (wr_left) begin
        left_q <= wb.wb_mosi[15:0];
      end
      if (push) begin
        wr_q <= wr_q + LVL_ONE;
      end
      if (pop) begin
        rd_q        <= rd_q + LVL_ONE;
        pcm_left_q  <= mem[rd_q[AW-1:0]][31:16];
        pcm_right_q <= mem[rd_q[AW-1:0]][15:0];
      end
      // On underrun the strobe still fires and the held samples are repeated.
      pcm_valid_q    <= pop_due;
      nearly_empty_q <= (level_d < LVL_NEARLY);

      if (state_q == ST_PREFILL) begin
        tick_q <= '0;
        if (level_d >= LVL_START) begin
          state_q   <= ST_PLAY;
          playing_q <= 1'b1;
        end
      end else begin
        if (pop_due) begin
          tick_q <= '0;
          if (underrun) begin
            state_q   <= ST_PREFILL;
            playing_q <= 1'b0;
            if (underrun_q != 16'hFFFF) begin
              underrun_q <= underrun_q + 16'd1;
            end
          end
        end else begin
          tick_q <= tick_q + TICK_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Randomised and directed bench for audio_sample_fifo with a queue-based playback model.
module tb_audio_sample_fifo;
  localparam int DEPTH = 256;
  localparam int TPS   = 680;
  localparam int START = 40;
  localparam int NE    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcm_valid;
  logic [15:0] pcm_left, pcm_right;
  logic        playing, nearly_empty;

  always #5 clk = ~clk;

  audio_sample_fifo_if bus ();

  audio_sample_fifo #(
    .DEPTH(DEPTH), .TICKS_PER_SAMPLE(TPS), .START_LEVEL(START), .NEARLY_EMPTY_LEVEL(NE)
  ) dut (
    .clk(clk), .reset(reset), .wb(bus.slave),
    .pcm_valid(pcm_valid), .pcm_left(pcm_left), .pcm_right(pcm_right),
    .playing(playing), .nearly_empty(nearly_empty)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  // Strobe log: every pcm_valid with its data and cycle number.
  logic [31:0] strobe_data[$];
  int          strobe_cyc[$];
  always @(negedge clk) begin
    if (pcm_valid === 1'b1) begin
      strobe_data.push_back({pcm_left, pcm_right});
      strobe_cyc.push_back(cyc_n);
    end
  end

  // Behavioural model: a queue of stereo entries plus a play/prefill flag and sample phase.
  logic [31:0] m_q[$];
  logic [15:0] m_left, m_under, m_l, m_r;
  bit          m_play, m_valid, armed;
  int          m_phase;
  int          lvl;
  bit          due, popping, req, wr_right, stall, was_play;
  logic [31:0] exp_miso;

  initial armed = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      check("pcm_valid", pcm_valid, m_valid);
      check("pcm_left", pcm_left, m_l);
      check("pcm_right", pcm_right, m_r);
      check("playing", playing, m_play);
      check("nearly_empty", nearly_empty, m_q.size() < NE);
    end
    if (reset === 1'b1) begin
      check("ack_in_reset", bus.wb_ack, 1'b0);
      m_q.delete();
      m_left = 0; m_under = 0; m_l = 0; m_r = 0;
      m_play = 0; m_valid = 0; m_phase = 0;
      armed = 1'b1;
    end else if (armed) begin
      lvl      = m_q.size();
      due      = m_play && (m_phase == TPS - 1);
      popping  = due && (lvl > 0);
      req      = bus.wb_cyc && bus.wb_stb;
      wr_right = req && bus.wb_we && (bus.wb_adr == 8);
      stall    = wr_right && (lvl == DEPTH) && !popping;
      check("wb_ack", bus.wb_ack, req && !stall);
      if (req && !bus.wb_we && bus.wb_adr != 4 && bus.wb_adr != 8) begin
        exp_miso = (bus.wb_adr == 9) ? {m_under, m_play, lvl < NE, 14'(lvl)} : 32'd0;
        check("wb_miso", bus.wb_miso, exp_miso);
      end
      was_play = m_play;
      m_valid  = due;
      if (due) begin
        m_phase = 0;
        if (popping) begin
          {m_l, m_r} = m_q.pop_front();
        end else begin
          if (m_under != 16'hFFFF) m_under++;
          m_play = 0;
        end
      end else if (m_play) begin
        m_phase++;
      end
      if (wr_right && !stall) m_q.push_back({m_left, bus.wb_mosi[15:0]});
      if (req && bus.wb_we && bus.wb_adr == 4) m_left = bus.wb_mosi[15:0];
      if (!was_play && m_q.size() >= START) begin
        m_play  = 1;
        m_phase = 0;
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output int ack_cyc);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we; bus.wb_adr = a; bus.wb_mosi = d;
    rdata = 32'd0;
    ack_cyc = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.wb_ack === 1'b1) begin
        rdata = bus.wb_miso;
        ack_cyc = cyc_n;
        break;
      end
      @(posedge clk); #1;
    end
    if (ack_cyc < 0) check("wb_ack_timeout", bus.wb_ack, 1'b1);
    @(posedge clk); #1;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    int c;
    wb_xfer(1'b1, a, d, r, c);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    int c;
    wb_xfer(1'b0, a, 32'd0, r, c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int k, input int limit);
    for (int n = 0; n < limit; n++) begin
      if (strobe_data.size() >= k) break;
      @(posedge clk);
    end
    #1;
    if (strobe_data.size() < k) check("strobe_timeout", strobe_data.size(), k);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 95000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  a;
    int          ack_c, p40, base, start_c, sel;

    reset = 1'b1;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    bus.wb_adr = 4'd0; bus.wb_mosi = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    rd(4'd9, r);
    check("status_after_reset", r, 32'h0000_4000);

    // 39 pairs: just below the start threshold.
    for (int i = 0; i < 39; i++) begin
      wr(4'd4, 32'(i));
      wr(4'd8, 32'(-i));
    end
    rd(4'd9, r);
    check("status_39_entries", r, 32'h0000_0027);
    idle(2000);
    check("no_strobe_in_prefill", strobe_data.size(), 0);
    check("not_playing_39", playing, 1'b0);

    wr(4'd4, 32'd39);
    wb_xfer(1'b1, 4'd8, 32'(-39), r, ack_c);
    @(negedge clk);
    check("playing_after_40th", playing, 1'b1);
    wait_strobes(1, 1000);
    check("first_strobe_latency", strobe_cyc[0] - ack_c, 681);
    check("first_strobe_data", strobe_data[0], 32'h0000_0000);
    wait_strobes(41, 41 * TPS + 2000);
    check("strobe_interval", strobe_cyc[1] - strobe_cyc[0], TPS);
    for (int i = 0; i < 40; i++) check("drain_data", strobe_data[i], {16'(i), 16'(-i)});
    check("underrun_repeat", strobe_data[40], {16'd39, 16'(-39)});
    check("underrun_interval", strobe_cyc[40] - strobe_cyc[39], TPS);
    check("stopped_after_underrun", playing, 1'b0);
    rd(4'd9, r);
    check("status_after_underrun", r, 32'h0001_4000);

    // Left-hold reuse, then fill to full while playback starts.
    base = strobe_data.size();
    wr(4'd4, 32'h1234);
    wr(4'd4, 32'h5678);
    wr(4'd8, 32'h0001);
    wr(4'd8, 32'h0002);
    p40 = 0;
    for (int i = 0; i < 254; i++) begin
      wr(4'd4, $urandom);
      wb_xfer(1'b1, 4'd8, $urandom, r, ack_c);
      if (i == 37) p40 = ack_c;
    end
    rd(4'd9, r);
    check("status_full", r, 32'h0001_8100);
    start_c = cyc_n;
    wb_xfer(1'b1, 4'd8, 32'h0000_0BAD, r, ack_c);
    check("stall_held", ack_c > start_c, 1'b1);
    check("stall_release_cycle", ack_c, p40 + TPS);
    wait_strobes(base + 1, 100);
    check("pop_with_release", strobe_cyc[base], ack_c + 1);
    check("left_overwrite", strobe_data[base], 32'h5678_0001);
    rd(4'd9, r);
    check("status_still_full", r, 32'h0001_8100);
    wait_strobes(base + 2, 1000);
    check("left_reuse", strobe_data[base + 1], 32'h5678_0002);

    // Refill to full, stall a write, then reset underneath it.
    wr(4'd8, 32'h0000_0003);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
    bus.wb_adr = 4'd8; bus.wb_mosi = 32'h0000_0004;
    repeat (5) begin
      @(negedge clk);
      check("ack_low_when_full", bus.wb_ack, 1'b0);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("ack_low_in_reset", bus.wb_ack, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_pcm", {pcm_left, pcm_right}, 32'd0);
    check("reset_playing", playing, 1'b0);
    check("reset_nearly_empty", nearly_empty, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    rd(4'd9, r);
    check("status_after_midreset", r, 32'h0000_4000);

    // Random traffic: a write-heavy burst, then a long sparse stretch that drains.
    wr(4'd8, 32'h0000_0055);
    for (int t = 0; t < 190; t++) begin
      sel = (t < 120) ? $urandom_range(0, 9) : (($urandom_range(0, 19) < 2) ? 0 : 7 + $urandom_range(0, 3));
      if (sel <= 2) begin
        wr(4'd4, $urandom);
        wr(4'd8, $urandom);
      end else if (sel == 3) begin
        wr(4'd8, $urandom);
      end else if (sel == 4) begin
        wr(4'd4, $urandom);
      end else if (sel == 5) begin
        rd(4'd9, r);
      end else if (sel == 6) begin
        do a = 4'($urandom_range(0, 15)); while (a == 4 || a == 8 || a == 9);
        if ($urandom_range(0, 1) == 1) wr(a, $urandom);
        else rd(a, r);
      end else if (t < 120) begin
        idle($urandom_range(1, 40));
      end else begin
        if (sel == 7) rd(4'd9, r);
        idle($urandom_range(300, 800));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
